id_issue_queue: RTL and testbench

Decoupling queue and sequencer between the instruction decoder and the issue stage. Accepts one decoded scoreboard entry per cycle, buffers up to DEPTH entries in program order, and presents them to issue through a valid/ack handshake. Optionally serialises control flow so that at most one unresolved control-flow instruction is in flight. Replaces the single ID/issue pipeline register when decode and issue rates diverge.

---
 rtl/id_issue_queue.sv | 137 +++++++++++++
 tb/tb_id_issue_queue.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/id_issue_queue.sv
// ---------------------------------------------------------------------------
// id_issue_queue
//
// Decoupling queue between the instruction decoder and the issue stage.
// Holds up to DEPTH decoded entries in program order and hands them to issue
// through a valid/ack handshake. When CF_SERIAL is nonzero, accepting a
// control-flow entry stops further accepts until cf_resolved_i arrives.
//
// Optional feature: define ISSUE_QUEUE_BYPASS_EN to forward the incoming
// entry straight to the issue port when the queue is empty. This gives zero
// latency and adds a combinational path from dec_* to issue_*.
//
// Parameters
//   DEPTH     number of slots (power of two, >= 2)
//   CF_SERIAL nonzero: a pending control-flow entry gates dec_ready_o
//   DATA_W    width of a decoded scoreboard entry
//
// Ports
//   clk_i, rst_i          clock, asynchronous active-high reset
//   flush_i               drop every buffered entry and the pending CF flag
//   dec_valid_i/ready_o   decode-side handshake
//   dec_entry_i           decoded entry
//   dec_is_ctrl_flow_i    entry is a control-flow instruction
//   issue_valid_o/ack_i   issue-side handshake
//   issue_entry_o         head entry
//   issue_is_ctrl_flow_o  head entry is control flow
//   cf_resolved_i         outstanding control-flow instruction resolved
//   count_o               number of buffered entries (registered)
//   cf_pending_o          unresolved control-flow entry accepted (registered)
// ---------------------------------------------------------------------------
module id_issue_queue #(
  parameter int DEPTH     = 4,
  parameter int CF_SERIAL = 1,
  parameter int DATA_W    = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     dec_valid_i,
  output logic                     dec_ready_o,
  input  logic [DATA_W-1:0]        dec_entry_i,
  input  logic                     dec_is_ctrl_flow_i,
  output logic                     issue_valid_o,
  output logic [DATA_W-1:0]        issue_entry_o,
  output logic                     issue_is_ctrl_flow_o,
  input  logic                     issue_ack_i,
  input  logic                     cf_resolved_i,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     cf_pending_o
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] entry_q [DEPTH];
  logic [DEPTH-1:0]  ctrl_q;
  logic [AW:0]       wptr_q, wptr_d;
  logic [AW:0]       rptr_q, rptr_d;
  logic [AW:0]       count_q, count_d;
  logic              cf_pending_q, cf_pending_d;

  logic          empty, full, cf_block;
  logic          push, pop, bypass, bypass_ack, wr_en, rd_en;
  logic [AW-1:0] widx, ridx;

  assign widx  = wptr_q[AW-1:0];
  assign ridx  = rptr_q[AW-1:0];
  assign empty = (wptr_q == rptr_q);
  assign full  = (widx == ridx) && (wptr_q[AW] != rptr_q[AW]);

  assign cf_block    = (CF_SERIAL != 0) && cf_pending_q;
  // An ack while full frees the head slot in the same edge, so a push can
  // land in it and throughput stays at one per cycle.
  assign dec_ready_o = (!full || issue_ack_i) && !cf_block && !flush_i;

`ifdef ISSUE_QUEUE_BYPASS_EN
  // dec_ready_o already folds in flush_i and the CF gate.
  assign bypass = empty && dec_valid_i && dec_ready_o;
`else
  assign bypass = 1'b0;
`endif

  assign issue_valid_o        = !empty || bypass;
  assign issue_entry_o        = bypass ? dec_entry_i        : entry_q[ridx];
  assign issue_is_ctrl_flow_o = bypass ? dec_is_ctrl_flow_i : ctrl_q[ridx];

  assign push = dec_valid_i && dec_ready_o;
  assign pop  = issue_valid_o && issue_ack_i;

  // A bypassed entry consumed in the same cycle never touches storage.
  assign bypass_ack = bypass && issue_ack_i;
  assign wr_en      = push && !bypass_ack;
  assign rd_en      = pop  && !bypass_ack;

  always_comb begin
    wptr_d       = wptr_q;
    rptr_d       = rptr_q;
    count_d      = count_q;
    cf_pending_d = cf_pending_q;
    if (flush_i) begin
      wptr_d       = '0;
      rptr_d       = '0;
      count_d      = '0;
      cf_pending_d = 1'b0;
    end else begin
      if (wr_en) wptr_d = wptr_q + 1'b1;
      if (rd_en) rptr_d = rptr_q + 1'b1;
      count_d = count_q + {{AW{1'b0}}, wr_en} - {{AW{1'b0}}, rd_en};
      // Set beats clear when a new branch arrives with a resolve pulse.
      if (push && dec_is_ctrl_flow_i) cf_pending_d = 1'b1;
      else if (cf_resolved_i)         cf_pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q       <= '0;
      rptr_q       <= '0;
      count_q      <= '0;
      cf_pending_q <= 1'b0;
      ctrl_q       <= '0;
      for (int i = 0; i < DEPTH; i++) entry_q[i] <= '0;
    end else begin
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      count_q      <= count_d;
      cf_pending_q <= cf_pending_d;
      if (wr_en) begin
        entry_q[widx] <= dec_entry_i;
        ctrl_q[widx]  <= dec_is_ctrl_flow_i;
      end
    end
  end

  assign count_o      = count_q;
  assign cf_pending_o = cf_pending_q;

endmodule

// File: tb/tb_id_issue_queue.sv
module tb_id_issue_queue;

  localparam int DEPTH  = 4;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              flush = 1'b0;
  logic              dec_valid = 1'b0;
  logic              dec_ready;
  logic [DATA_W-1:0] dec_entry = '0;
  logic              dec_cf = 1'b0;
  logic              iss_valid;
  logic [DATA_W-1:0] iss_entry;
  logic              iss_cf;
  logic              iss_ack = 1'b0;
  logic              cf_res = 1'b0;
  logic [2:0]        count;
  logic              cf_pend;

  int nchk  = 0;
  int nfail = 0;
  logic mon_en = 1'b1;
  logic [DATA_W:0] exp_q[$];

  id_issue_queue #(.DEPTH(DEPTH), .CF_SERIAL(1), .DATA_W(DATA_W)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .dec_valid_i(dec_valid), .dec_ready_o(dec_ready),
    .dec_entry_i(dec_entry), .dec_is_ctrl_flow_i(dec_cf),
    .issue_valid_o(iss_valid), .issue_entry_o(iss_entry),
    .issue_is_ctrl_flow_o(iss_cf), .issue_ack_i(iss_ack),
    .cf_resolved_i(cf_res), .count_o(count), .cf_pending_o(cf_pend)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [DATA_W-1:0] e, input logic cf,
                       input logic ack, input logic res, input logic fl);
    dec_valid = v; dec_entry = e; dec_cf = cf;
    iss_ack = ack; cf_res = res; flush = fl;
  endtask

  task automatic idle();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Record accepted pushes at the falling edge, then advance past the next rise.
  task automatic tick();
    @(negedge clk);
    if (flush) exp_q.delete();
    else if (dec_valid && dec_ready) exp_q.push_back({dec_cf, dec_entry});
    @(posedge clk);
    #1;
  endtask

  // Monitor: every handshake at the issue port pops one expected entry.
  always @(negedge clk) begin
    if (mon_en && !rst && !flush && iss_ack) begin
      chk("ack_needs_valid", {63'd0, iss_valid}, 64'd1);
      if (iss_valid) begin
        if (exp_q.size() == 0) begin
          nchk++; nfail++;
          $display("FAIL unexpected_issue: got %0h, expected no entry", iss_entry);
        end else begin
          logic [DATA_W:0] e;
          e = exp_q.pop_front();
          chk("issue_entry", {31'd0, iss_cf, iss_entry}, {31'd0, e});
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 100000");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    #2;
    chk("rst_count",   {61'd0, count}, 64'd0);
    chk("rst_valid",   {63'd0, iss_valid}, 64'd0);
    chk("rst_cfpend",  {63'd0, cf_pend}, 64'd0);
    chk("rst_entry",   {32'd0, iss_entry}, 64'd0);
    chk("rst_ready",   {63'd0, dec_ready}, 64'd1);
    #10 rst = 1'b0;
    @(posedge clk); #1;

    // Fill to DEPTH without acks, then drain in order.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'hA000_0000 + i, 1'b0, 1'b0, 1'b0, 1'b0);
      #1 chk("fill_ready", {63'd0, dec_ready}, 64'd1);
      tick();
    end
    idle();
    #1;
    chk("full_count", {61'd0, count}, 64'd4);
    chk("full_ready", {63'd0, dec_ready}, 64'd0);
    chk("full_valid", {63'd0, iss_valid}, 64'd1);
    drive(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    #1 chk("full_ack_ready", {63'd0, dec_ready}, 64'd1);
    for (int i = 0; i < 4; i++) tick();
    idle();
    #1;
    chk("drain_count", {61'd0, count}, 64'd0);
    chk("drain_valid", {63'd0, iss_valid}, 64'd0);

    // Full queue with push and ack every cycle.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'hB000_0000 + i, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
    end
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'hC000_0000 + i, 1'b0, 1'b1, 1'b0, 1'b0);
      #1 chk("pp_ready", {63'd0, dec_ready}, 64'd1);
      tick();
      chk("pp_count", {61'd0, count}, 64'd4);
    end
    drive(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) tick();
    idle();
    #1 chk("pp_drain_count", {61'd0, count}, 64'd0);

    // Control-flow serialisation.
    drive(1'b1, 32'hD000_0001, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'hD000_0002, 1'b0, 1'b0, 1'b0, 1'b0);
      #1;
      chk("cf_pending_set", {63'd0, cf_pend}, 64'd1);
      chk("cf_ready_blocked", {63'd0, dec_ready}, 64'd0);
      tick();
    end
    drive(1'b1, 32'hD000_0002, 1'b0, 1'b0, 1'b1, 1'b0);
    #1 chk("cf_resolve_cycle_ready", {63'd0, dec_ready}, 64'd0);
    tick();
    drive(1'b1, 32'hD000_0002, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("cf_cleared", {63'd0, cf_pend}, 64'd0);
    chk("cf_reopen_ready", {63'd0, dec_ready}, 64'd1);
    tick();
    drive(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(); tick();
    // Set and resolve in the same cycle: set wins.
    drive(1'b1, 32'hD000_0003, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    idle();
    #1;
    chk("cf_set_wins", {63'd0, cf_pend}, 64'd1);
    chk("cf_set_wins_ready", {63'd0, dec_ready}, 64'd0);
    drive(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    idle();
    #1;
    chk("cf_final_clear", {63'd0, cf_pend}, 64'd0);
    chk("cf_final_count", {61'd0, count}, 64'd0);

    // Flush with three entries held and a push in the flush cycle.
    drive(1'b1, 32'hE000_0000, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b1, 32'hE000_0001, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b1, 32'hE000_0002, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    idle();
    #1 chk("pre_flush_count", {61'd0, count}, 64'd3);
    drive(1'b1, 32'hEEEE_EEEE, 1'b0, 1'b1, 1'b0, 1'b1);
    #1 chk("flush_ready", {63'd0, dec_ready}, 64'd0);
    tick();
    idle();
    #1;
    chk("flush_count",  {61'd0, count}, 64'd0);
    chk("flush_valid",  {63'd0, iss_valid}, 64'd0);
    chk("flush_cfpend", {63'd0, cf_pend}, 64'd0);
    drive(1'b1, 32'hF000_0001, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0); tick();
    idle();
    #1 chk("post_flush_count", {61'd0, count}, 64'd0);

    // Asynchronous reset between edges.
    drive(1'b1, 32'h1111_0000, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b1, 32'h1111_0001, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    idle();
    #2 rst = 1'b1;
    #1;
    chk("arst_count",  {61'd0, count}, 64'd0);
    chk("arst_valid",  {63'd0, iss_valid}, 64'd0);
    chk("arst_cfpend", {63'd0, cf_pend}, 64'd0);
    chk("arst_entry",  {32'd0, iss_entry}, 64'd0);
    exp_q.delete();
    #3 rst = 1'b0;
    @(posedge clk); #1;
    drive(1'b1, 32'h2222_0001, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    idle();
    #1;
    chk("arst_latency_valid", {63'd0, iss_valid}, 64'd1);
    chk("arst_latency_count", {61'd0, count}, 64'd1);
    drive(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0); tick();
    idle();
    #1 chk("arst_drain_count", {61'd0, count}, 64'd0);

`ifdef ISSUE_QUEUE_BYPASS_EN
    mon_en = 1'b0;
    drive(1'b1, 32'h3333_0001, 1'b0, 1'b1, 1'b0, 1'b0);
    #1;
    chk("byp_valid", {63'd0, iss_valid}, 64'd1);
    chk("byp_entry", {32'd0, iss_entry}, 64'h3333_0001);
    tick();
    idle();
    #1 chk("byp_ack_count", {61'd0, count}, 64'd0);
    drive(1'b1, 32'h3333_0002, 1'b0, 1'b0, 1'b0, 1'b0);
    #1 chk("byp_noack_entry", {32'd0, iss_entry}, 64'h3333_0002);
    tick();
    idle();
    #1 chk("byp_noack_count", {61'd0, count}, 64'd1);
    exp_q.delete();
    exp_q.push_back({1'b0, 32'h3333_0002});
    mon_en = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0); tick();
    idle();
    #1;
`endif

    chk("leftover_expected", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
